// File: rtl/coin_pkg.sv
// Shared definitions for the coin credit unit: idle code, coin value map
// and the qualifier state encoding.
package coin_pkg;

   // All-ones coin code means "no coin in the slot"; slice to the coin width.
   localparam logic [31:0] COIN_IDLE = '1;

   // Qualifier FSM state encoding.
   typedef logic [1:0] coin_state_t;
   localparam coin_state_t ST_IDLE     = 2'd0;
   localparam coin_state_t ST_QUAL     = 2'd1;
   localparam coin_state_t ST_WAIT_REL = 2'd2;

   // Map a coin code to its value; 0 marks an unmapped (or idle) code.
   function automatic logic [15:0] coin_to_value(input logic [31:0] code,
                                                 input int unsigned coin_w);
      logic [31:0] idle_code;
      idle_code = COIN_IDLE >> (32 - coin_w);
      if (code == idle_code) begin
         return 16'd0;
      end
      case (code)
         32'd0:   return 16'd1;
         32'd1:   return 16'd5;
         32'd2:   return 16'd10;
         default: return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// Coin-slot qualifier: a code must be seen DEBOUNCE samples in a row to
// qualify, then the slot must read idle DEBOUNCE samples in a row before
// another coin can be seen. qualified/code are combinational so the top
// can register its pulse on the same edge the coin qualifies.
module coin_debounce
   import coin_pkg::*;
#(
   parameter int unsigned COIN_W   = 2,
   parameter int unsigned DEBOUNCE = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [COIN_W-1:0] coin_in,
   output logic              qualified,
   output logic [COIN_W-1:0] code
);

   localparam int unsigned       CNT_W      = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0]  DEB_CNT    = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1);
   localparam logic [COIN_W-1:0] IDLE_CODE  = COIN_IDLE[COIN_W-1:0];

   coin_state_t       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [COIN_W-1:0] code_q, code_d;
   logic              qual_d;
   logic              sample_idle;
   logic [CNT_W-1:0]  count_inc;

   assign sample_idle = (coin_in == IDLE_CODE);
   assign count_inc   = count_q + ONE_CNT;
   assign qualified   = qual_d;
   assign code        = code_d;

   // Next-state logic for the qualify / wait-for-release sequence.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      code_d  = code_q;
      qual_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!sample_idle) begin
               code_d = coin_in;
               if (ONE_CNT == DEB_CNT) begin
                  qual_d  = 1'b1;
                  state_d = ST_WAIT_REL;
                  count_d = '0;
               end else begin
                  state_d = ST_QUAL;
                  count_d = ONE_CNT;
               end
            end
         end
         ST_QUAL: begin
            if (sample_idle) begin
               // Glitch: drop back without a pulse.
               state_d = ST_IDLE;
               count_d = '0;
            end else if (coin_in == code_q) begin
               if (count_inc == DEB_CNT) begin
                  qual_d  = 1'b1;
                  state_d = ST_WAIT_REL;
                  count_d = '0;
               end else begin
                  count_d = count_inc;
               end
            end else begin
               // Code changed mid-qualification: restart on the new code.
               code_d  = coin_in;
               count_d = ONE_CNT;
            end
         end
         ST_WAIT_REL: begin
            if (sample_idle) begin
               if (count_inc == DEB_CNT) begin
                  state_d = ST_IDLE;
                  count_d = '0;
               end else begin
                  count_d = count_inc;
               end
            end else begin
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         code_q  <= IDLE_CODE;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         code_q  <= code_d;
      end
   end

endmodule

// File: rtl/coin_credit_unit.sv
// Coin credit unit: debounced coin acceptance into a bounded credit
// register, with deduct and refund handshakes. All outputs registered.
module coin_credit_unit
   import coin_pkg::*;
#(
   parameter int unsigned COIN_W     = 2,
   parameter int unsigned VAL_W      = 5,
   parameter int unsigned CREDIT_W   = 8,
   parameter int unsigned CREDIT_MAX = 255,
   parameter int unsigned DEBOUNCE   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [COIN_W-1:0]   coin_in,
   input  logic                deduct_req,
   input  logic [CREDIT_W-1:0] deduct_amt,
   input  logic                refund_req,
   output logic [VAL_W-1:0]    coin_value,
   output logic                coin_valid,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                deduct_ack,
   output logic                deduct_err,
   output logic                refund_valid,
   output logic [CREDIT_W-1:0] refund_amt
);

   localparam logic [CREDIT_W:0] MAX_X = (CREDIT_W+1)'(CREDIT_MAX);

   logic                qualified;
   logic [COIN_W-1:0]   q_code;
   logic [VAL_W-1:0]    coin_val_w;
   logic                deduct_ok;
   logic [CREDIT_W-1:0] base;
   logic [CREDIT_W:0]   sum;

   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [VAL_W-1:0]    coin_value_q, coin_value_d;
   logic                coin_valid_q, coin_valid_d;
   logic                coin_reject_q, coin_reject_d;
   logic                deduct_ack_q, deduct_ack_d;
   logic                deduct_err_q, deduct_err_d;
   logic                refund_valid_q, refund_valid_d;
   logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;

   coin_debounce #(
      .COIN_W   (COIN_W),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .coin_in   (coin_in),
      .qualified (qualified),
      .code      (q_code)
   );

   assign coin_val_w = VAL_W'(coin_to_value(32'(q_code), COIN_W));

   // Refund beats deduct; the deduct is judged against the pre-add credit
   // and a same-cycle coin is added on top of whatever remains.
   always_comb begin
      deduct_ok      = deduct_req && !refund_req && (deduct_amt <= credit_q);
      base           = refund_req ? '0 : (deduct_ok ? credit_q - deduct_amt : credit_q);
      sum            = {1'b0, base} + (CREDIT_W+1)'(coin_val_w);
      credit_d       = base;
      coin_value_d   = coin_value_q;
      coin_valid_d   = 1'b0;
      coin_reject_d  = 1'b0;
      deduct_ack_d   = deduct_ok;
      deduct_err_d   = deduct_req && !deduct_ok;
      refund_valid_d = refund_req;
      refund_amt_d   = refund_req ? credit_q : refund_amt_q;
      if (qualified) begin
         if ((coin_val_w == '0) || (sum > MAX_X)) begin
            coin_reject_d = 1'b1;
         end else begin
            coin_valid_d = 1'b1;
            credit_d     = sum[CREDIT_W-1:0];
            coin_value_d = coin_val_w;
         end
      end
   end

   // Output and credit registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         credit_q       <= '0;
         coin_value_q   <= '0;
         coin_valid_q   <= 1'b0;
         coin_reject_q  <= 1'b0;
         deduct_ack_q   <= 1'b0;
         deduct_err_q   <= 1'b0;
         refund_valid_q <= 1'b0;
         refund_amt_q   <= '0;
      end else begin
         credit_q       <= credit_d;
         coin_value_q   <= coin_value_d;
         coin_valid_q   <= coin_valid_d;
         coin_reject_q  <= coin_reject_d;
         deduct_ack_q   <= deduct_ack_d;
         deduct_err_q   <= deduct_err_d;
         refund_valid_q <= refund_valid_d;
         refund_amt_q   <= refund_amt_d;
      end
   end

   assign credit       = credit_q;
   assign coin_value   = coin_value_q;
   assign coin_valid   = coin_valid_q;
   assign coin_reject  = coin_reject_q;
   assign deduct_ack   = deduct_ack_q;
   assign deduct_err   = deduct_err_q;
   assign refund_valid = refund_valid_q;
   assign refund_amt   = refund_amt_q;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Directed, table-driven bench for coin_credit_unit with default parameters.
module tb_coin_credit_unit;

   typedef struct packed {
      logic       cv;
      logic       cr;
      logic       ack;
      logic       err;
      logic       rv;
      logic [7:0] credit;
      logic [4:0] val;
      logic [7:0] ramt;
   } out_t;

   typedef struct {
      logic [1:0] coin;
      logic       dreq;
      logic [7:0] damt;
      logic       rreq;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] coin_in;
   logic       deduct_req;
   logic [7:0] deduct_amt;
   logic       refund_req;
   logic [4:0] coin_value;
   logic       coin_valid;
   logic       coin_reject;
   logic [7:0] credit;
   logic       deduct_ack;
   logic       deduct_err;
   logic       refund_valid;
   logic [7:0] refund_amt;

   out_t act;
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Builder bookkeeping: held outputs carried from the last hand-written entry.
   logic [7:0] b_credit = 8'd0;
   logic [4:0] b_val    = 5'd0;
   logic [7:0] b_ramt   = 8'd0;

   always #5 clk = ~clk;

   coin_credit_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_in      (coin_in),
      .deduct_req   (deduct_req),
      .deduct_amt   (deduct_amt),
      .refund_req   (refund_req),
      .coin_value   (coin_value),
      .coin_valid   (coin_valid),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .deduct_ack   (deduct_ack),
      .deduct_err   (deduct_err),
      .refund_valid (refund_valid),
      .refund_amt   (refund_amt)
   );

   assign act = '{cv: coin_valid, cr: coin_reject, ack: deduct_ack, err: deduct_err,
                  rv: refund_valid, credit: credit, val: coin_value, ramt: refund_amt};

   function automatic out_t mk(input logic cv, input logic cr, input logic ack,
                               input logic err, input logic rv, input logic [7:0] c,
                               input logic [4:0] v, input logic [7:0] r);
      out_t o;
      o = '{cv: cv, cr: cr, ack: ack, err: err, rv: rv, credit: c, val: v, ramt: r};
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("check %s: cv=%b cr=%b ack=%b err=%b rv=%b credit=%0d val=%0d ramt=%0d ok",
                  name, act.cv, act.cr, act.ack, act.err, act.rv, act.credit, act.val, act.ramt);
      end else begin
         $display("FAIL %s: got cv=%b cr=%b ack=%b err=%b rv=%b credit=%0d val=%0d ramt=%0d, expected cv=%b cr=%b ack=%b err=%b rv=%b credit=%0d val=%0d ramt=%0d",
                  name, act.cv, act.cr, act.ack, act.err, act.rv, act.credit, act.val, act.ramt,
                  exp.cv, exp.cr, exp.ack, exp.err, exp.rv, exp.credit, exp.val, exp.ramt);
      end
   endtask

   task automatic push(input logic [1:0] coin, input logic dreq, input logic [7:0] damt,
                       input logic rreq, input logic cv, input logic cr, input logic ack,
                       input logic err, input logic rv, input logic [7:0] c,
                       input logic [4:0] v, input logic [7:0] r);
      vec_t e;
      e.coin = coin;
      e.dreq = dreq;
      e.damt = damt;
      e.rreq = rreq;
      e.exp  = mk(cv, cr, ack, err, rv, c, v, r);
      vecs.push_back(e);
      b_credit = c;
      b_val    = v;
      b_ramt   = r;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         push(2'b11, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b_credit, b_val, b_ramt);
   endtask

   // Two samples of the code, then two idle samples to release the slot.
   task automatic add_coin(input logic [1:0] code, input logic [4:0] v,
                           input logic [7:0] new_credit, input logic ok);
      push(code, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b_credit, b_val, b_ramt);
      push(code, 1'b0, 8'd0, 1'b0, ok, !ok, 1'b0, 1'b0, 1'b0, new_credit,
           ok ? v : b_val, b_ramt);
      idle(2);
   endtask

   initial begin
      rst_n      = 1'b0;
      coin_in    = 2'b11;
      deduct_req = 1'b0;
      deduct_amt = 8'd0;
      refund_req = 1'b0;

      // Hold 00 two cycles -> coin value 1, credit 1.
      add_coin(2'b00, 5'd1, 8'd1, 1'b1);
      // One-cycle 01 glitch -> nothing.
      push(2'b01, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 5'd1, 8'd0);
      idle(2);
      // Hold 10 for 20 cycles -> exactly one accept.
      push(2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 5'd1, 8'd0);
      push(2'b10, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11, 5'd10, 8'd0);
      for (int k = 0; k < 18; k++)
         push(2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11, 5'd10, 8'd0);
      idle(2);
      add_coin(2'b01, 5'd5, 8'd16, 1'b1);
      // Deduct too much, then a valid deduct, then zero.
      push(2'b11, 1'b1, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd16, 5'd5, 8'd0);
      push(2'b11, 1'b1, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 5'd5, 8'd0);
      push(2'b11, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 5'd5, 8'd0);
      // Refund, then deduct against empty credit.
      push(2'b11, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 5'd5, 8'd1);
      push(2'b11, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 5'd5, 8'd1);
      add_coin(2'b10, 5'd10, 8'd10, 1'b1);
      add_coin(2'b10, 5'd10, 8'd20, 1'b1);
      add_coin(2'b10, 5'd10, 8'd30, 1'b1);
      // Refund + deduct + coin 10 in one cycle.
      push(2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30, 5'd10, 8'd1);
      push(2'b10, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 5'd10, 8'd30);
      idle(2);
      // Coin 5 with accepted deduct 4: 10 - 4 + 5.
      push(2'b01, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10, 5'd10, 8'd30);
      push(2'b01, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd11, 5'd5, 8'd30);
      idle(2);
      // Deduct exactly the credit.
      push(2'b11, 1'b1, 8'd11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 5'd5, 8'd30);
      // Build up to 250, then the overflow boundary.
      for (int k = 0; k < 25; k++)
         add_coin(2'b10, 5'd10, 8'(10 * (k + 1)), 1'b1);
      add_coin(2'b01, 5'd5, 8'd255, 1'b1);
      add_coin(2'b00, 5'd1, 8'd255, 1'b0);
      // Coin 1 with refund at 255: refund 255, credit becomes 1.
      push(2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 5'd5, 8'd30);
      push(2'b00, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 5'd1, 8'd255);
      idle(2);

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset", mk(0, 0, 0, 0, 0, 8'd0, 5'd0, 8'd0));
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         coin_in    = vecs[i].coin;
         deduct_req = vecs[i].dreq;
         deduct_amt = vecs[i].damt;
         refund_req = vecs[i].rreq;
         @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end
      deduct_req = 1'b0;
      refund_req = 1'b0;

      // Reset during qualification, then a coin held through reset release.
      coin_in = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_qual", mk(0, 0, 0, 0, 0, 8'd0, 5'd0, 8'd0));
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_first_sample", mk(0, 0, 0, 0, 0, 8'd0, 5'd0, 8'd0));
      @(negedge clk);
      check("post_rst_held_coin", mk(1, 0, 0, 0, 0, 8'd1, 5'd1, 8'd0));
      @(negedge clk);
      check("wait_rel_no_repeat", mk(0, 0, 0, 0, 0, 8'd1, 5'd1, 8'd0));
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_in_wait_rel", mk(0, 0, 0, 0, 0, 8'd0, 5'd0, 8'd0));
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("requal_after_rst", mk(1, 0, 0, 0, 0, 8'd1, 5'd1, 8'd0));
      coin_in = 2'b11;
      @(negedge clk);
      @(negedge clk);
      check("release", mk(0, 0, 0, 0, 0, 8'd1, 5'd1, 8'd0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
